// File: rtl/eespfal_phase_driver.sv
// Upstream driver for the 64-bit EE-SPFAL adiabatic core.
// Latches single-rail operands, presents them dual-rail, sequences the four
// overlapping power-clock phases and discharge controls, then captures the
// core's dual-rail result and checks rail integrity.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | rails null, all discharges on; waits for start
// S_DISCH   | pre-evaluation global discharge, DIS_CYCLES long
// S_RUN     | PHASES+1 slots of PHASE_CYCLES; phase i powered in slots i,i+1
// S_RECOVER | post-evaluation discharge, rails null, DIS_CYCLES long
// S_DONE    | busy dropped; done pulses on the edge that returns to IDLE
module eespfal_phase_driver #(
  parameter int BIT_SIZE     = 64,
  parameter int PHASES       = 4,
  parameter int PHASE_CYCLES = 8,
  parameter int DIS_CYCLES   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIT_SIZE-1:0] x_in,
  input  logic [BIT_SIZE-1:0] k_in,
  output logic                busy,
  output logic                done,
  output logic [BIT_SIZE-1:0] result,
  output logic                rail_err,
  output logic [PHASES-1:0]   clk_top,
  output logic [PHASES-1:0]   Dis_top,
  output logic                Dis_Phase_top,
  output logic [BIT_SIZE-1:0] x_top,
  output logic [BIT_SIZE-1:0] x_bar_top,
  output logic [BIT_SIZE-1:0] k_top,
  output logic [BIT_SIZE-1:0] k_bar_top,
  input  logic [BIT_SIZE-1:0] s_top,
  input  logic [BIT_SIZE-1:0] s_bar_top
);

  localparam int MAX_CYC = (PHASE_CYCLES > DIS_CYCLES) ? PHASE_CYCLES : DIS_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int SLOT_W  = $clog2(PHASES + 2);

  localparam logic [CW-1:0]     PH_LAST   = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0]     DIS_LAST  = CW'(DIS_CYCLES - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PHASES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISCH,
    S_RUN,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [BIT_SIZE-1:0] x_q;
  logic [BIT_SIZE-1:0] k_q;
  logic                busy_q;
  logic                done_q;
  logic [BIT_SIZE-1:0] result_q;
  logic                rail_err_q;
  logic [PHASES-1:0]   clk_top_q;
  logic [PHASES-1:0]   dis_top_q;
  logic                dis_phase_q;
  logic [BIT_SIZE-1:0] x_top_q;
  logic [BIT_SIZE-1:0] x_bar_top_q;
  logic [BIT_SIZE-1:0] k_top_q;
  logic [BIT_SIZE-1:0] k_bar_top_q;

  logic [SLOT_W-1:0]   slot_d;
  logic [PHASES-1:0]   clk_slot_d;
  logic [PHASES-1:0]   dis_slot_d;
  logic                rail_err_d;

  // Phase i is powered for slot i (evaluate) and slot i+1 (hold).
  function automatic logic [PHASES-1:0] slot_clk(input logic [SLOT_W-1:0] s);
    logic [PHASES-1:0] r;
    for (int i = 0; i < PHASES; i++) begin
      r[i] = (int'(s) == i) || (int'(s) == i + 1);
    end
    return r;
  endfunction

  // Phase i is discharged only once its hold slot has passed.
  function automatic logic [PHASES-1:0] slot_dis(input logic [SLOT_W-1:0] s);
    logic [PHASES-1:0] r;
    for (int i = 0; i < PHASES; i++) begin
      r[i] = (int'(s) >= i + 2);
    end
    return r;
  endfunction

  // Next-slot phase pattern and rail-integrity flag of the live core outputs.
  always_comb begin
    slot_d     = slot_q + SLOT_W'(1);
    clk_slot_d = slot_clk(slot_d);
    dis_slot_d = slot_dis(slot_d);
    rail_err_d = |(s_top ~^ s_bar_top);
  end

  // Sequencer: state, timers and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      x_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      rail_err_q  <= 1'b0;
      clk_top_q   <= '0;
      dis_top_q   <= '1;
      dis_phase_q <= 1'b1;
      x_top_q     <= '0;
      x_bar_top_q <= '0;
      k_top_q     <= '0;
      k_bar_top_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= x_in;
            k_q     <= k_in;
            busy_q  <= 1'b1;
            cnt_q   <= DIS_LAST;
            state_q <= S_DISCH;
          end
        end

        S_DISCH: begin
          if (cnt_q == '0) begin
            // Drop discharges and present operands together with phase 0.
            slot_q      <= '0;
            cnt_q       <= PH_LAST;
            clk_top_q   <= slot_clk('0);
            dis_top_q   <= slot_dis('0);
            dis_phase_q <= 1'b0;
            x_top_q     <= x_q;
            x_bar_top_q <= ~x_q;
            k_top_q     <= k_q;
            k_bar_top_q <= ~k_q;
            state_q     <= S_RUN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_RUN: begin
          if (cnt_q == '0) begin
            if (slot_q == LAST_SLOT) begin
              // Last phase still powered here, so the core outputs are valid.
              result_q    <= s_top;
              rail_err_q  <= rail_err_d;
              cnt_q       <= DIS_LAST;
              clk_top_q   <= '0;
              dis_top_q   <= '1;
              dis_phase_q <= 1'b1;
              x_top_q     <= '0;
              x_bar_top_q <= '0;
              k_top_q     <= '0;
              k_bar_top_q <= '0;
              state_q     <= S_RECOVER;
            end else begin
              slot_q    <= slot_d;
              cnt_q     <= PH_LAST;
              clk_top_q <= clk_slot_d;
              dis_top_q <= dis_slot_d;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_RECOVER: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign rail_err      = rail_err_q;
  assign clk_top       = clk_top_q;
  assign Dis_top       = dis_top_q;
  assign Dis_Phase_top = dis_phase_q;
  assign x_top         = x_top_q;
  assign x_bar_top     = x_bar_top_q;
  assign k_top         = k_top_q;
  assign k_bar_top     = k_bar_top_q;

endmodule

// File: doc/eespfal_phase_driver.md
Name: eespfal_phase_driver

Overview:
Digital upstream driver for the 64-bit EE-SPFAL adiabatic core. It latches single-rail operands x and k, expands them to dual-rail, and sequences the four overlapping power-clock phases plus discharge controls that the core consumes. At the end of each operation it captures the core's dual-rail result and flags rail-integrity violations. It sits between the user-project register interface and the adiabatic macro.

Parameters:
BIT_SIZE, 64, operand/result width; must match the core.
PHASES, 4, number of power-clock phases (clk_top/Dis_top width); fixed at 4.
PHASE_CYCLES, 8, clk cycles per phase slot; must be >= 2.
DIS_CYCLES, 2, clk cycles of global discharge before and after evaluation; must be >= 1.

Ports:
clk  input  1  digital system clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
x_in  input  BIT_SIZE  single-rail operand x.
k_in  input  BIT_SIZE  single-rail operand k.
busy  output  1  high from the accepting edge until done.
done  output  1  one-cycle pulse when result/rail_err are valid.
result  output  BIT_SIZE  captured s_top; held until the next capture.
rail_err  output  1  captured: 1 if any bit has s_top == s_bar_top.
clk_top  output  PHASES  power-clock enables, one per phase.
Dis_top  output  PHASES  per-phase discharge enables.
Dis_Phase_top  output  1  global discharge.
x_top, x_bar_top, k_top, k_bar_top  output  BIT_SIZE each  dual-rail operands.
s_top, s_bar_top  input  BIT_SIZE each  dual-rail result from the core.

Behaviour:
- All outputs registered. Reset, or IDLE with no start: clk_top=0, Dis_top=all 1s, Dis_Phase_top=1, all operand rails 0 (null), busy=0, done=0, result=0, rail_err=0.
- FSM states: IDLE, DISCH, RUN, RECOVER, DONE.
- IDLE: if start=1, latch x_in and k_in, set busy=1, and go to DISCH. start is ignored in every other state; no queueing.
- DISCH: hold DIS_CYCLES cycles with all discharges asserted and rails null. On the exit edge: Dis_top=0, Dis_Phase_top=0, x_top=x, x_bar_top=~x, k_top=k, k_bar_top=~k. Go to RUN.
- RUN: 5 slots numbered 0..4, each PHASE_CYCLES cycles, tracked by a slot counter and a cycle counter.
  - clk_top[i]=1 exactly during slots i and i+1 (evaluate then hold); otherwise 0.
  - Dis_top[i]=1 during slots where clk_top[i]=0 after phase i has completed, i.e. slot >= i+2; otherwise 0.
  - Operand rails stay stable throughout RUN.
  - On the last cycle of slot 4 (clk_top[3] high): result<=s_top and rail_err<=|~(s_top^s_bar_top). Then go to RECOVER.
- RECOVER: clk_top=0, Dis_top=all 1s, Dis_Phase_top=1, rails null, for DIS_CYCLES cycles. Then go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE. A start seen in the DONE cycle is ignored.
- Timing: busy is high for DIS_CYCLES + 5*PHASE_CYCLES + DIS_CYCLES cycles (44 with defaults). done is asserted 45 edges after the accepting edge.
- rst_n low mid-operation: outputs take their reset values immediately (asynchronous); any capture is lost and no done pulse is issued.
- Invariants in every cycle:
  - x_top & x_bar_top == 0.
  - k_top & k_bar_top == 0.
  - clk_top[i] & Dis_top[i] == 0.

Test Plan:
- Reset while idle -> Dis_top=4'hF, Dis_Phase_top=1, clk_top=0, all rails 0, busy=0, done=0.
- x_in=64'h0123_4567_89AB_CDEF, k_in=64'hFFFF_0000_FFFF_0000, start pulse, core model s=x^k, s_bar=~s -> x_bar_top=64'hFEDC_BA98_7654_3210; done exactly 45 cycles after the start edge; result=64'hFEDC_4567_7654_CDEF; rail_err=0.
- Phase waveform check -> clk_top[0] rises 2 cycles after the start edge (after DISCH) and is high 16 cycles; clk_top[1..3] each lag the previous phase by 8 cycles; Dis_top[0] goes high when clk_top[0] falls.
- Core model forces s_top[17]=s_bar_top[17]=1 -> rail_err=1 with done; result bit 17 = 1.
- start held high continuously -> back-to-back operations, each with busy high for 44 cycles; starts during busy or DONE never shorten or restart an operation.
- rst_n asserted at slot 2 of RUN -> outputs return to reset values asynchronously; no done; result=0; a new start after release completes normally.
